// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encoding.
// The ALU controller and alu_seq both use these constants.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Start/done request bus between the datapath (master) and alu_seq (slave).
// Master stalls on busy_o; results are valid from the done_o cycle onward.
interface alu_seq_if #(parameter int WIDTH = 32);

    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [4:0]       shamt_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;
    logic             illegal_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i, shamt_i,
        input  busy_o, done_o, result_o, zero_o, overflow_o, illegal_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
        output busy_o, done_o, result_o, zero_o, overflow_o, illegal_o
    );

endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier: load captures operands, each step retires one multiplier bit.
// CYCLES steps per product; prod is the accumulator including the current step, last flags the final one.
module mul_iter #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic             last,
    output logic [WIDTH-1:0] prod
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

    // Only the low WIDTH bits of the product are ever needed, so the
    // accumulator and multiplicand simply truncate as they shift.
    assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last = (cnt_q == CW'(CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= mcand_in;
            mplier_q <= mplier_in;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= prod;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops done 1 cycle after accept, MUL done MUL_CYCLES cycles after accept.
// Requests are accepted only while idle; start while busy is dropped, never queued.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_seq_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic [4:0]       shamt_q;

    logic             accept;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] exec_res;
    logic             exec_ovf;
    logic             exec_ill;

    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             ill_q;

    assign accept = (state_q == ST_IDLE) && bus.start_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (bus.ctrl_i == ALU_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            shamt_q <= '0;
        end else if (accept) begin
            ctrl_q  <= bus.ctrl_i;
            src1_q  <= bus.src1_i;
            src2_q  <= bus.src2_i;
            shamt_q <= bus.shamt_i;
        end
    end

    mul_iter #(
        .WIDTH  (WIDTH),
        .CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  (bus.src1_i),
        .mplier_in (bus.src2_i),
        .last      (mul_last),
        .prod      (mul_prod)
    );

    assign sum  = src1_q + src2_q;
    assign diff = src1_q - src2_q;

    always_comb begin
        exec_res = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (ctrl_q)
            ALU_ADD: begin
                exec_res = sum;
                exec_ovf = (src1_q[MSB] == src2_q[MSB]) && (sum[MSB] != src1_q[MSB]);
            end
            ALU_SUB: begin
                exec_res = diff;
                exec_ovf = (src1_q[MSB] != src2_q[MSB]) && (diff[MSB] != src1_q[MSB]);
            end
            ALU_AND:  exec_res = src1_q & src2_q;
            ALU_OR:   exec_res = src1_q | src2_q;
            ALU_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(src1_q) < $signed(src2_q))};
            ALU_SLL:  exec_res = src2_q << shamt_q;
            ALU_SLLV: exec_res = src2_q << src1_q[4:0];
            ALU_SRL:  exec_res = src2_q >> shamt_q;
            ALU_SRLV: exec_res = src2_q >> src1_q[4:0];
            default:  exec_ill = 1'b1;
        endcase
    end

    // Result and flags update together on the completing edge and are held until the next one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_EXEC) begin
                done_q   <= 1'b1;
                result_q <= exec_res;
                zero_q   <= (exec_res == '0);
                ovf_q    <= exec_ovf;
                ill_q    <= exec_ill;
            end else if ((state_q == ST_MUL) && mul_last) begin
                done_q   <= 1'b1;
                result_q <= mul_prod;
                zero_q   <= (mul_prod == '0);
                ovf_q    <= 1'b0;
                ill_q    <= 1'b0;
            end
        end
    end

    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.done_o     = done_q;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = ovf_q;
    assign bus.illegal_o  = ill_q;

endmodule
